// File: rtl/cell_exerciser.sv
// Exhaustive truth-table checker for a combinational cell of up to six inputs.
// Optional first-failing-vector capture: define CELL_EXER_FIRST_FAIL_EN.
module cell_exerciser #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   tt,
    output logic [N_IN-1:0]      vec_out,
    input  logic                 cell_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 fail,
    output logic [N_IN-1:0]      first_fail_vec
);

    localparam int unsigned     DEPTH       = 2**N_IN;
    localparam int unsigned     SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST    = '1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FIN} state_t;

    state_t           state, state_next;
    logic [DEPTH-1:0] snap;
    logic [SW-1:0]    settle_cnt;
    logic             load, cmp_en, vec_step, vec_clr, settle_inc;
    logic             mismatch;

    assign mismatch = (cell_out != snap[vec_out]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        cmp_en     = 1'b0;
        vec_step   = 1'b0;
        vec_clr    = 1'b0;
        settle_inc = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    vec_clr    = 1'b1;
                    state_next = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_next = SAMPLE;
                end else begin
                    settle_inc = 1'b1;
                end
            end
            SAMPLE: begin
                // The compare is taken even when aborting this cycle.
                cmp_en = 1'b1;
                if (abort) begin
                    vec_clr    = 1'b1;
                    state_next = IDLE;
                end else if (vec_out == VEC_LAST) begin
                    state_next = FIN;
                end else begin
                    vec_step   = 1'b1;
                    state_next = DRIVE;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap       <= '0;
            settle_cnt <= '0;
            vec_out    <= '0;
            err_cnt    <= '0;
        end else if (load) begin
            snap       <= tt;
            settle_cnt <= '0;
            vec_out    <= '0;
            err_cnt    <= '0;
        end else begin
            if (settle_inc) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (vec_step) begin
                vec_out    <= vec_out + 1'b1;
                settle_cnt <= '0;
            end
            if (vec_clr) begin
                vec_out <= '0;
            end
            if (cmp_en && mismatch && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

`ifdef CELL_EXER_FIRST_FAIL_EN
    // err_cnt saturates rather than wrapping, so zero means no mismatch yet this run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_fail_vec <= '0;
        end else if (load) begin
            first_fail_vec <= '0;
        end else if (cmp_en && mismatch && (err_cnt == '0)) begin
            first_fail_vec <= vec_out;
        end
    end
`else
    assign first_fail_vec = '0;
`endif

    assign busy = (state != IDLE);
    assign done = (state == FIN);
    assign fail = |err_cnt;

endmodule

// File: tb/tb_cell_exerciser.sv
// Scoreboard bench for cell_exerciser: four instances with different widths
// and settle times, each driven by a truth-table-described cell model.
module tb_cell_exerciser;

    localparam int unsigned NIN [4] = '{1, 2, 4, 3};
    localparam int unsigned STL [4] = '{1, 2, 2, 2};
    localparam int unsigned CW  [4] = '{8, 8, 2, 8};

    typedef struct {
        int unsigned err;
        int unsigned ffv;
        bit          fl;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  start_a = '0;
    logic [3:0]  abort_a = '0;
    logic [63:0] tt_a  [4];
    logic [63:0] ctt_a [4];
    logic [3:0]  busy_a, done_a, fail_a;
    logic [7:0]  err_a [4];
    logic [5:0]  vec_a [4];
    logic [5:0]  ffv_a [4];

    logic [0:0] v0, f0;
    logic [1:0] v1, f1;
    logic [3:0] v2, f2;
    logic [2:0] v3, f3;
    logic [7:0] e0, e1, e3;
    logic [1:0] e2;

    int unsigned dcnt [4] = '{0, 0, 0, 0};
    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        sb [$];

    always #5 clk = ~clk;

    cell_exerciser #(.N_IN(1), .SETTLE(1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .start(start_a[0]), .abort(abort_a[0]),
        .tt(tt_a[0][1:0]), .vec_out(v0), .cell_out(ctt_a[0][6'(v0)]),
        .busy(busy_a[0]), .done(done_a[0]), .err_cnt(e0), .fail(fail_a[0]),
        .first_fail_vec(f0));

    cell_exerciser #(.N_IN(2), .SETTLE(2), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .start(start_a[1]), .abort(abort_a[1]),
        .tt(tt_a[1][3:0]), .vec_out(v1), .cell_out(ctt_a[1][6'(v1)]),
        .busy(busy_a[1]), .done(done_a[1]), .err_cnt(e1), .fail(fail_a[1]),
        .first_fail_vec(f1));

    cell_exerciser #(.N_IN(4), .SETTLE(2), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .start(start_a[2]), .abort(abort_a[2]),
        .tt(tt_a[2][15:0]), .vec_out(v2), .cell_out(ctt_a[2][6'(v2)]),
        .busy(busy_a[2]), .done(done_a[2]), .err_cnt(e2), .fail(fail_a[2]),
        .first_fail_vec(f2));

    cell_exerciser #(.N_IN(3), .SETTLE(2), .CNT_W(8)) u3 (
        .clk(clk), .rst(rst), .start(start_a[3]), .abort(abort_a[3]),
        .tt(tt_a[3][7:0]), .vec_out(v3), .cell_out(ctt_a[3][6'(v3)]),
        .busy(busy_a[3]), .done(done_a[3]), .err_cnt(e3), .fail(fail_a[3]),
        .first_fail_vec(f3));

    assign vec_a[0] = 6'(v0);
    assign vec_a[1] = 6'(v1);
    assign vec_a[2] = 6'(v2);
    assign vec_a[3] = 6'(v3);
    assign ffv_a[0] = 6'(f0);
    assign ffv_a[1] = 6'(f1);
    assign ffv_a[2] = 6'(f2);
    assign ffv_a[3] = 6'(f3);
    assign err_a[0] = e0;
    assign err_a[1] = e1;
    assign err_a[2] = 8'(e2);
    assign err_a[3] = e3;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_a[i] === 1'b1) dcnt[i] <= dcnt[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input int k, input logic [63:0] t, input logic [63:0] c);
        exp_t        e;
        int unsigned nv  = 1 << NIN[k];
        int unsigned sat = (1 << CW[k]) - 1;
        bit          found = 1'b0;
        e.err = 0;
        e.ffv = 0;
        for (int unsigned v = 0; v < nv; v++) begin
            if (t[v[5:0]] !== c[v[5:0]]) begin
`ifdef CELL_EXER_FIRST_FAIL_EN
                if (!found) e.ffv = v;
`endif
                found = 1'b1;
                if (e.err < sat) e.err++;
            end
        end
        e.fl  = (e.err != 0);
        e.cyc = nv * (STL[k] + 1) + 1;
        return e;
    endfunction

    // Full run; disturb re-pulses start and inverts tt a few cycles in.
    task automatic run_full(input int k, input logic [63:0] t, input logic [63:0] c,
                            input bit disturb);
        exp_t        e;
        int unsigned cyc;
        int unsigned d0;
        tt_a[k]  = t;
        ctt_a[k] = c;
        sb.push_back(model(k, t, c));
        d0 = dcnt[k];
        @(negedge clk);
        start_a[k] = 1'b1;
        @(negedge clk);
        start_a[k] = 1'b0;
        cyc = 1;
        check("busy_after_accept", 64'(busy_a[k]), 64'd1);
        while (done_a[k] !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (disturb && cyc == 3) begin
                start_a[k] = 1'b1;
                tt_a[k]    = ~t;
            end
            if (disturb && cyc == 4) start_a[k] = 1'b0;
        end
        check("done_seen", 64'(done_a[k]), 64'd1);
        e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("err_cnt", 64'(err_a[k]), 64'(e.err));
        check("fail", 64'(fail_a[k]), 64'(e.fl));
        check("first_fail_vec", 64'(ffv_a[k]), 64'(e.ffv));
        check("busy_in_fin", 64'(busy_a[k]), 64'd1);
        @(negedge clk);
        check("done_one_cycle", 64'(done_a[k]), 64'd0);
        check("busy_after_fin", 64'(busy_a[k]), 64'd0);
        check("err_hold", 64'(err_a[k]), 64'(e.err));
        repeat (3) @(negedge clk);
        check("done_pulses", 64'(dcnt[k] - d0), 64'd1);
    endtask

    initial begin
        int unsigned d0;
        int unsigned guard;
        for (int i = 0; i < 4; i++) begin
            tt_a[i]  = '0;
            ctt_a[i] = '0;
        end
        repeat (2) @(negedge clk);
        check("rst_vec", 64'(vec_a[1]), 64'd0);
        check("rst_busy", 64'(busy_a[1]), 64'd0);
        check("rst_done", 64'(done_a[1]), 64'd0);
        check("rst_err", 64'(err_a[1]), 64'd0);
        check("rst_fail", 64'(fail_a[1]), 64'd0);
        check("rst_ffv", 64'(ffv_a[1]), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_full(0, 64'h1, 64'h1, 1'b0);          // inverter, correct
        run_full(1, 64'h7, 64'h0, 1'b0);          // nand2 stuck at 0
        run_full(1, 64'h6, 64'he, 1'b0);          // xor2 vs or2: only vector 3 differs
        run_full(2, 64'h0, 64'hffff, 1'b0);       // 16 mismatches, 2-bit counter saturates

        // Abort in the SAMPLE of vector 4; that vector's mismatch is still counted.
        tt_a[3]  = 64'h7f;
        ctt_a[3] = 64'h6f;
        d0 = dcnt[3];
        @(negedge clk);
        start_a[3] = 1'b1;
        @(negedge clk);
        start_a[3] = 1'b0;
        guard = 0;
        while (vec_a[3] !== 6'd4 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("reach_vec4", 64'(vec_a[3]), 64'd4);
        repeat (2) @(negedge clk);
        check("busy_before_abort", 64'(busy_a[3]), 64'd1);
        abort_a[3] = 1'b1;
        @(negedge clk);
        abort_a[3] = 1'b0;
        check("abort_busy", 64'(busy_a[3]), 64'd0);
        check("abort_vec", 64'(vec_a[3]), 64'd0);
        check("abort_err", 64'(err_a[3]), 64'd1);
        check("abort_fail", 64'(fail_a[3]), 64'd1);
`ifdef CELL_EXER_FIRST_FAIL_EN
        check("abort_ffv", 64'(ffv_a[3]), 64'd4);
`else
        check("abort_ffv", 64'(ffv_a[3]), 64'd0);
`endif
        repeat (5) @(negedge clk);
        check("abort_no_done", 64'(dcnt[3] - d0), 64'd0);
        check("abort_err_hold", 64'(err_a[3]), 64'd1);

        run_full(3, 64'h7f, 64'h7f, 1'b0);        // clean run after abort
        run_full(1, 64'h8, 64'hc, 1'b1);          // start re-pulse and tt change ignored

        // Asynchronous reset in the middle of a run.
        tt_a[1]  = 64'h7;
        ctt_a[1] = 64'h0;
        d0 = dcnt[1];
        @(negedge clk);
        start_a[1] = 1'b1;
        @(negedge clk);
        start_a[1] = 1'b0;
        repeat (7) @(negedge clk);
        check("midrun_err", 64'(err_a[1]), 64'd2);
        check("midrun_vec", 64'(vec_a[1]), 64'd2);
        #2 rst = 1'b1;
        #1;
        check("arst_vec", 64'(vec_a[1]), 64'd0);
        check("arst_busy", 64'(busy_a[1]), 64'd0);
        check("arst_done", 64'(done_a[1]), 64'd0);
        check("arst_err", 64'(err_a[1]), 64'd0);
        check("arst_fail", 64'(fail_a[1]), 64'd0);
        check("arst_ffv", 64'(ffv_a[1]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("arst_no_done", 64'(dcnt[1] - d0), 64'd0);
        check("arst_idle", 64'(busy_a[1]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
